// File: rtl/bpsk_pkg.sv
// Shared types, constants and arithmetic helpers for the BPSK + AWGN sample scheduler.
package bpsk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWaitTick,
    StReq
  } state_e;

  localparam logic [15:0]        MIN_DIV     = 16'd32;
  localparam logic signed [15:0] DEFAULT_AMP = 16'sd8192;
  // Wide enough for the largest legal noise timeout (23).
  localparam int unsigned        WAIT_W      = 5;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s > 17'sd32767) begin
      return 16'sh7fff;
    end else if (s < -17'sd32768) begin
      return 16'sh8000;
    end
    return s[15:0];
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Sample-rate counter: latches the clamped divisor on load and strobes tick once per period.
module rate_divider
  import bpsk_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic        load,
  input  logic        run,
  input  logic [15:0] div_sample,
  output logic        tick
);

  logic [15:0] div_q;
  logic [15:0] count_q;

  assign tick = run && (count_q == div_q - 16'd1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_q   <= MIN_DIV;
      count_q <= '0;
    end else begin
      if (load) begin
        div_q <= clamp_div(div_sample);
      end
      // Held at zero while idle so the first FETCH cycle sees count 0.
      if (!run || tick) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/bpsk_awgn_sched.sv
// BPSK modulator that fetches data bits, requests AWGN noise per sample and emits
// saturated noisy samples at a programmable sample rate.
module bpsk_awgn_sched
  import bpsk_pkg::*;
#(
  parameter logic signed [15:0] AMP           = DEFAULT_AMP,
  parameter int unsigned        NOISE_TIMEOUT = 15
) (
  input  logic               MCLK,
  input  logic               n_reset,
  input  logic               enable,
  input  logic [15:0]        div_sample,
  input  logic [7:0]         samples_per_bit,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic               noise_req,
  input  logic               noise_ack,
  input  logic signed [15:0] noise_in,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               data_clk,
  output logic               bpsk_clk,
  output logic               underrun,
  output logic               noise_timeout
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(NOISE_TIMEOUT - 1);

  state_e             state_q;
  logic               bit_q;
  logic [7:0]         idx_q;
  logic [7:0]         spb_q;
  logic [WAIT_W-1:0]  wait_q;

  logic               tick;
  logic               run;
  logic               load;
  logic               transfer;
  logic               last_idx;
  logic               wait_done;
  logic signed [15:0] sym;
  logic signed [15:0] noisy;

  assign run       = (state_q != StIdle);
  assign load      = (state_q == StIdle) && enable;
  assign transfer  = bit_valid && bit_ready;
  assign last_idx  = (idx_q == spb_q - 8'd1);
  assign wait_done = (wait_q == WAIT_LAST);
  assign sym       = bit_q ? AMP : -AMP;
  assign noisy     = sat_add(sym, noise_in);

  rate_divider u_rate_divider (
    .clk        (MCLK),
    .n_reset    (n_reset),
    .load       (load),
    .run        (run),
    .div_sample (div_sample),
    .tick       (tick)
  );

  always_ff @(posedge MCLK or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= StIdle;
      bit_q         <= 1'b0;
      idx_q         <= '0;
      spb_q         <= 8'd1;
      wait_q        <= '0;
      bit_ready     <= 1'b0;
      noise_req     <= 1'b0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      data_clk      <= 1'b0;
      bpsk_clk      <= 1'b0;
      underrun      <= 1'b0;
      noise_timeout <= 1'b0;
    end else if (!enable) begin
      // Abort: any in-flight sample is dropped, rate indicators keep their level.
      state_q       <= StIdle;
      idx_q         <= '0;
      wait_q        <= '0;
      bit_ready     <= 1'b0;
      noise_req     <= 1'b0;
      sample_valid  <= 1'b0;
      underrun      <= 1'b0;
      noise_timeout <= 1'b0;
    end else begin
      sample_valid  <= 1'b0;
      underrun      <= 1'b0;
      noise_timeout <= 1'b0;
      if (tick) begin
        bpsk_clk <= ~bpsk_clk;
      end

      unique case (state_q)
        StIdle: begin
          spb_q     <= (samples_per_bit == 8'd0) ? 8'd1 : samples_per_bit;
          idx_q     <= '0;
          bit_ready <= 1'b1;
          state_q   <= StFetch;
        end

        StFetch: begin
          if (transfer) begin
            bit_q     <= bit_in;
            idx_q     <= '0;
            data_clk  <= ~data_clk;
            bit_ready <= 1'b0;
            if (tick) begin
              wait_q    <= '0;
              noise_req <= 1'b1;
              state_q   <= StReq;
            end else begin
              state_q <= StWaitTick;
            end
          end else if (tick) begin
            // No bit arrived in time: send a zero bit and flag it.
            underrun  <= 1'b1;
            bit_q     <= 1'b0;
            idx_q     <= '0;
            data_clk  <= ~data_clk;
            bit_ready <= 1'b0;
            wait_q    <= '0;
            noise_req <= 1'b1;
            state_q   <= StReq;
          end
        end

        StWaitTick: begin
          if (tick) begin
            wait_q    <= '0;
            noise_req <= 1'b1;
            state_q   <= StReq;
          end
        end

        StReq: begin
          // An ack on the expiry cycle still wins over the timeout.
          if (noise_ack || wait_done) begin
            sample_out    <= noise_ack ? noisy : sym;
            sample_valid  <= 1'b1;
            noise_timeout <= ~noise_ack;
            noise_req     <= 1'b0;
            wait_q        <= '0;
            if (last_idx) begin
              bit_ready <= 1'b1;
              state_q   <= StFetch;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= StWaitTick;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
